// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions: bus data width and the RAM arbiter state encoding.
package mem_arbiter_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of cycles a requester has waited ungranted; at_max flags the
// edge on which the count lands on MAX_WAIT.
module mem_arbiter_starve_counter #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic at_max
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = '0;
    if (waiting) begin
      count_d = (count_q == LIMIT) ? count_q : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max = (count_d == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter between the CPU control unit (port 0) and the loader/IO
// (port 1), with lock-held ownership, alternating ties and a sticky starvation flag.
//
// state | meaning
// IDLE  | nobody owns the RAM; address/data/we parked at zero
// OWN0  | requester 0 owns the RAM and drives it combinationally
// OWN1  | requester 1 owns the RAM and drives it combinationally
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_SIZE = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                lock0,
  input  logic                lock1,
  input  logic                we0,
  input  logic                we1,
  input  logic [RAM_SIZE-1:0] addr0,
  input  logic [RAM_SIZE-1:0] addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
  output logic [RAM_SIZE-1:0] ram_address,
  output logic                we,
  output logic [DATA_W-1:0]   ram_out,
  input  logic [DATA_W-1:0]   ram_in,
  output logic                fault
);

  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_served_q;
  logic       rvalid0_q;
  logic       rvalid1_q;
  logic       fault_q;
  logic       acc0;
  logic       acc1;
  logic       at_max0;
  logic       at_max1;

  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);
  assign acc0 = req0 & gnt0;
  assign acc1 = req1 & gnt1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_served_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      // Without a lock, a waiting peer takes over after a single access.
      OWN0: begin
        if (lock0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (lock1) begin
          state_d = OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_address = '0;
    we          = 1'b0;
    ram_out     = '0;
    case (state_q)
      OWN0: begin
        ram_address = addr0;
        we          = we0 & req0;
        ram_out     = wdata0;
      end
      OWN1: begin
        ram_address = addr1;
        we          = we1 & req1;
        ram_out     = wdata1;
      end
      default: ;
    endcase
  end

  // Read-data return is tracked per port so it survives an ownership switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rvalid0_q <= acc0 & ~we0;
      rvalid1_q <= acc1 & ~we1;
      fault_q   <= fault_q | at_max0 | at_max1;
      if (acc0) begin
        last_served_q <= 1'b0;
      end else if (acc1) begin
        last_served_q <= 1'b1;
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rvalid0_q ? ram_in : '0;
  assign rdata1  = rvalid1_q ? ram_in : '0;
  assign fault   = fault_q;

  mem_arbiter_starve_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve0 (
    .clk     (clk),
    .rst     (rst),
    .waiting (req0 & ~gnt0),
    .at_max  (at_max0)
  );

  mem_arbiter_starve_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve1 (
    .clk     (clk),
    .rst     (rst),
    .waiting (req1 & ~gnt1),
    .at_max  (at_max1)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vectors with expected grant/RAM-port values and a
// read-data scoreboard, plus reset-mid-lock and starvation sequences.
module tb_mem_arbiter;

  typedef struct {
    logic        rst;
    logic        r0, l0, w0;
    logic [15:0] a0, d0;
    logic        r1, l1, w1;
    logic [15:0] a1, d1;
    logic        g0, g1, ewe;
    logic [15:0] eaddr, eout, erd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1, ram_address, ram_out, ram_in;
  logic        we, fault;

  int checks = 0;
  int errors = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        exp_rv0 = 1'b0;
  logic        exp_rv1 = 1'b0;

  vec_t tbl[$];
  vec_t seq_rst[$];
  vec_t seq_stv[$];

  logic [15:0]   mem [0:1023];
  logic [1023:0] written;
  logic          mem_clr;

  always #5 clk = ~clk;

  mem_arbiter #(.RAM_SIZE(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_address(ram_address), .we(we), .ram_out(ram_out), .ram_in(ram_in),
    .fault(fault)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0005) return 16'h1234;
    if (a == 16'h0010) return 16'hBEEF;
    return a ^ 16'h5A5A;
  endfunction

  // RAM model: synchronous read, data one cycle after the address.
  always @(posedge clk) begin
    if (mem_clr) begin
      written <= '0;
    end else if (we) begin
      mem[ram_address[9:0]]     <= ram_out;
      written[ram_address[9:0]] <= 1'b1;
    end
    ram_in <= written[ram_address[9:0]] ? mem[ram_address[9:0]] : init_val(ram_address);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [15:0] e;
    @(posedge clk);
    #1;
    rst = v.rst;
    req0 = v.r0; lock0 = v.l0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; lock1 = v.l1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    @(negedge clk);
    chk("gnt0", 32'(gnt0), 32'(v.g0));
    chk("gnt1", 32'(gnt1), 32'(v.g1));
    chk("we", 32'(we), 32'(v.ewe));
    chk("ram_address", 32'(ram_address), 32'(v.eaddr));
    chk("ram_out", 32'(ram_out), 32'(v.eout));
    chk("rvalid0", 32'(rvalid0), 32'(exp_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(exp_rv1));
    if (exp_rv0 && q0.size() > 0) begin
      e = q0.pop_front();
      chk("rdata0", 32'(rdata0), 32'(e));
    end else begin
      chk("rdata0_idle", 32'(rdata0), 32'h0);
    end
    if (exp_rv1 && q1.size() > 0) begin
      e = q1.pop_front();
      chk("rdata1", 32'(rdata1), 32'(e));
    end else begin
      chk("rdata1_idle", 32'(rdata1), 32'h0);
    end
    exp_rv0 = !v.rst && v.g0 && v.r0 && !v.w0;
    exp_rv1 = !v.rst && v.g1 && v.r1 && !v.w1;
    if (exp_rv0) q0.push_back(v.erd);
    if (exp_rv1) q1.push_back(v.erd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req0 = 0; lock0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; lock1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

    // fields: rst, r0,l0,w0,a0,d0, r1,l1,w1,a1,d1, g0,g1,we,addr,out, read data
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,0,0,              0,0,0,0,0,0});
    // single read of 0x0005
    tbl.push_back('{0, 1,0,0,'h5,0,          0,0,0,0,0,              0,0,0,0,0,0});
    tbl.push_back('{0, 1,0,0,'h5,0,          0,0,0,0,0,              1,0,0,'h5,0,'h1234});
    tbl.push_back('{0, 0,0,1,'h5,'h7777,     0,0,0,0,0,              1,0,0,'h5,'h7777,0});
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,0,0,              0,0,0,0,0,0});
    tbl.push_back('{1, 0,0,0,0,0,            0,0,0,0,0,              0,0,0,0,0,0});
    // continuous writes from both sides alternate
    tbl.push_back('{0, 1,0,1,'h100,'hA000,   1,0,1,'h180,'hB000,     0,0,0,0,0,0});
    tbl.push_back('{0, 1,0,1,'h100,'hA000,   1,0,1,'h180,'hB000,     1,0,1,'h100,'hA000,0});
    tbl.push_back('{0, 1,0,1,'h100,'hA000,   1,0,1,'h180,'hB000,     0,1,1,'h180,'hB000,0});
    tbl.push_back('{0, 1,0,1,'h100,'hA000,   1,0,1,'h180,'hB000,     1,0,1,'h100,'hA000,0});
    tbl.push_back('{0, 1,0,1,'h100,'hA000,   1,0,1,'h180,'hB000,     0,1,1,'h180,'hB000,0});
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,0,0,              1,0,0,0,0,0});
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,0,0,              0,0,0,0,0,0});
    // read back what port 1 wrote
    tbl.push_back('{0, 0,0,0,0,0,            1,0,0,'h180,0,          0,0,0,0,0,0});
    tbl.push_back('{0, 0,0,0,0,0,            1,0,0,'h180,0,          0,1,0,'h180,0,'hB000});
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,'h180,0,          0,1,0,'h180,0,0});
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,0,0,              0,0,0,0,0,0});
    // locked three-access push sequence while port 1 waits to read
    tbl.push_back('{0, 1,1,1,'h110,'h1111,   1,0,0,'h10,0,           0,0,0,0,0,0});
    tbl.push_back('{0, 1,1,1,'h110,'h1111,   1,0,0,'h10,0,           1,0,1,'h110,'h1111,0});
    tbl.push_back('{0, 1,1,1,'h111,'h2222,   1,0,0,'h10,0,           1,0,1,'h111,'h2222,0});
    tbl.push_back('{0, 1,0,1,'h112,'h3333,   1,0,0,'h10,0,           1,0,1,'h112,'h3333,0});
    tbl.push_back('{0, 0,0,0,0,0,            1,0,0,'h10,0,           0,1,0,'h10,0,'hBEEF});
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,'h10,0,           0,1,0,'h10,0,0});
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,0,0,              0,0,0,0,0,0});
    // read on port 0 returns while port 1 already owns
    tbl.push_back('{0, 1,0,0,'h10,0,         1,0,1,'h120,'hCAFE,     0,0,0,0,0,0});
    tbl.push_back('{0, 1,0,0,'h10,0,         1,0,1,'h120,'hCAFE,     1,0,0,'h10,0,'hBEEF});
    tbl.push_back('{0, 0,0,0,0,0,            1,0,1,'h120,'hCAFE,     0,1,1,'h120,'hCAFE,0});
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,0,0,              0,1,0,0,0,0});
    tbl.push_back('{0, 0,0,0,0,0,            0,0,0,0,0,              0,0,0,0,0,0});

    seq_rst.push_back('{0, 0,0,0,0,0,        1,0,0,'h10,0,           0,0,0,0,0,0});
    seq_rst.push_back('{0, 0,0,0,0,0,        1,0,0,'h10,0,           0,1,0,'h10,0,'hBEEF});
    seq_rst.push_back('{1, 0,0,0,0,0,        1,1,0,'h10,0,           0,1,0,'h10,0,'hBEEF});
    seq_rst.push_back('{0, 0,0,0,0,0,        1,1,1,'h130,'h5555,     0,0,0,0,0,0});
    seq_rst.push_back('{0, 0,0,0,0,0,        0,0,0,0,0,              0,1,0,0,0,0});
    seq_rst.push_back('{0, 0,0,0,0,0,        0,0,0,0,0,              0,0,0,0,0,0});

    seq_stv.push_back('{0, 1,1,1,'h140,'h0A0A, 1,0,1,'h141,'h0B0B,   0,0,0,0,0,0});
    for (int i = 0; i < 5; i++)
      seq_stv.push_back('{0, 1,1,1,'h140,'h0A0A, 1,0,1,'h141,'h0B0B, 1,0,1,'h140,'h0A0A,0});
    seq_stv.push_back('{0, 1,0,1,'h140,'h0A0A, 1,0,1,'h141,'h0B0B,   1,0,1,'h140,'h0A0A,0});
    seq_stv.push_back('{0, 0,0,0,0,0,          1,0,1,'h141,'h0B0B,   0,1,1,'h141,'h0B0B,0});
    seq_stv.push_back('{0, 0,0,0,0,0,          0,0,0,0,0,            0,1,0,0,0,0});
    seq_stv.push_back('{0, 0,0,0,0,0,          0,0,0,0,0,            0,0,0,0,0,0});

    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      if (i == 0) chk("fault_after_reset", 32'(fault), 32'h0);
    end

    // reset while port 1 holds a lock with a read in flight
    for (int i = 0; i < seq_rst.size(); i++) begin
      apply(seq_rst[i]);
      if (i == 0) chk("fault_sticky", 32'(fault), 32'h1);
      if (i == 3) chk("fault_cleared", 32'(fault), 32'h0);
    end

    // port 1 starved by a six-cycle lock on port 0
    for (int i = 0; i < seq_stv.size(); i++) begin
      apply(seq_stv[i]);
      if (i <= 2) chk("fault_early", 32'(fault), 32'h0);
      if (i >= 4) chk("fault_set", 32'(fault), 32'h1);
    end

    chk("sb_drain0", 32'(q0.size()), 32'h0);
    chk("sb_drain1", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
